ball_motion_ctrl: RTL and testbench

Parametrised ball motion engine for the VGA game. It sits between the collision detector (iCrash) and the sprite renderer (oBall_x/oBall_y) and moves the ball once per frame tick rather than once per pixel clock. Over the fixed-step, fixed-arena mover it adds per-axis programmable speed, arena-wall clamping with bounce, a serve/pause/miss state machine, and bounce/miss event pulses for scoring.

---
 rtl/ball_pkg.sv | 28 ++
 rtl/ball_axis.sv | 87 ++++++++
 rtl/ball_motion_ctrl.sv | 125 ++++++++++++
 tb/tb_ball_motion_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ball_pkg.sv
// Shared types and default arena geometry for the ball motion engine.
package ball_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_MISS   = 2'd3
    } ball_state_e;

    // An axis direction bit is 0 when moving toward its MIN bound and 1 toward MAX.
    localparam logic BALL_TOWARD_MIN   = 1'b0;
    localparam logic BALL_TOWARD_MAX   = 1'b1;
    localparam logic BALL_TOWARD_LEFT  = BALL_TOWARD_MIN;
    localparam logic BALL_TOWARD_RIGHT = BALL_TOWARD_MAX;
    localparam logic BALL_TOWARD_UP    = BALL_TOWARD_MIN;
    localparam logic BALL_TOWARD_DOWN  = BALL_TOWARD_MAX;

    localparam int BALL_COORD_W = 10;
    localparam int BALL_SPEED_W = 3;
    localparam int BALL_X_MIN   = 0;
    localparam int BALL_X_MAX   = 632;
    localparam int BALL_Y_MIN   = 0;
    localparam int BALL_Y_MAX   = 472;
    localparam int BALL_X_INIT  = 320;
    localparam int BALL_Y_INIT  = 240;

endpackage

// File: rtl/ball_axis.sv
// One motion axis: position/direction registers, crash reversal, step and wall clamp.
module ball_axis
    import ball_pkg::*;
#(
    parameter int COORD_W     = BALL_COORD_W,
    parameter int SPEED_W     = BALL_SPEED_W,
    parameter int MIN         = 0,
    parameter int MAX         = 632,
    parameter int INIT        = 320,
    parameter int MISS_AT_MAX = 0
)
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic               i_step,
    input  logic               i_crash_min,
    input  logic               i_crash_max,
    input  logic [SPEED_W-1:0] i_speed,
    output logic [COORD_W-1:0] o_pos,
    output logic               o_bounce,
    output logic               o_hit_max_miss
);

    // Two extra bits: one for overflow past MAX, one sign bit so underflow below MIN is visible.
    localparam int EXT_W = COORD_W + 2;
    localparam logic signed [EXT_W-1:0] MIN_S = EXT_W'(MIN);
    localparam logic signed [EXT_W-1:0] MAX_S = EXT_W'(MAX);

    logic [COORD_W-1:0]      r_pos;
    logic                    r_dir;
    logic                    w_dir_crash;
    logic                    w_dir_next;
    logic [COORD_W-1:0]      w_pos_next;
    logic signed [EXT_W-1:0] w_cur;
    logic signed [EXT_W-1:0] w_delta;
    logic signed [EXT_W-1:0] w_moved;
    logic                    w_below;
    logic                    w_above;

    function automatic logic reverse_on_crash(input logic dir, input logic cmin, input logic cmax);
        if (cmin && !cmax && (dir == BALL_TOWARD_MIN)) return BALL_TOWARD_MAX;
        if (cmax && !cmin && (dir == BALL_TOWARD_MAX)) return BALL_TOWARD_MIN;
        return dir;
    endfunction

    function automatic logic [COORD_W-1:0] clamp_pos(input logic signed [EXT_W-1:0] v);
        if (v < MIN_S) return COORD_W'(MIN);
        if (v > MAX_S) return COORD_W'(MAX);
        return v[COORD_W-1:0];
    endfunction

    assign w_dir_crash = reverse_on_crash(r_dir, i_crash_min, i_crash_max);
    assign w_cur       = $signed({2'b00, r_pos});
    assign w_delta     = $signed({{(EXT_W-SPEED_W){1'b0}}, i_speed});
    assign w_moved     = (w_dir_crash == BALL_TOWARD_MAX) ? (w_cur + w_delta) : (w_cur - w_delta);
    assign w_below     = (w_moved < MIN_S);
    assign w_above     = (w_moved > MAX_S);
    assign w_pos_next  = clamp_pos(w_moved);

    always_comb begin
        w_dir_next = w_dir_crash;
        if (w_below) begin
            w_dir_next = BALL_TOWARD_MAX;
        end else if (w_above && (MISS_AT_MAX == 0)) begin
            w_dir_next = BALL_TOWARD_MIN;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pos <= COORD_W'(INIT);
            r_dir <= BALL_TOWARD_MIN;
        end else if (i_load) begin
            r_pos <= COORD_W'(INIT);
            r_dir <= BALL_TOWARD_MIN;
        end else if (i_step) begin
            r_pos <= w_pos_next;
            r_dir <= w_dir_next;
        end
    end

    assign o_pos          = r_pos;
    assign o_bounce       = i_step && (w_dir_next != r_dir);
    assign o_hit_max_miss = i_step && w_above && (MISS_AT_MAX != 0);

endmodule

// File: rtl/ball_motion_ctrl.sv
// Frame-tick ball mover: serve/pause/miss FSM, sticky crash latches and scoring pulses.
module ball_motion_ctrl
    import ball_pkg::*;
#(
    parameter int COORD_W        = BALL_COORD_W,
    parameter int SPEED_W        = BALL_SPEED_W,
    parameter int X_MIN          = BALL_X_MIN,
    parameter int X_MAX          = BALL_X_MAX,
    parameter int Y_MIN          = BALL_Y_MIN,
    parameter int Y_MAX          = BALL_Y_MAX,
    parameter int X_INIT         = BALL_X_INIT,
    parameter int Y_INIT         = BALL_Y_INIT,
    parameter int MISS_ON_BOTTOM = 1
)
(
    input  logic               iVGA_CLK,
    input  logic               iRST_n,
    input  logic               iFrame_tick,
    input  logic               iServe,
    input  logic               iPause,
    input  logic [3:0]         iCrash,
    input  logic [SPEED_W-1:0] iSpeed_x,
    input  logic [SPEED_W-1:0] iSpeed_y,
    output logic [COORD_W-1:0] oBall_x,
    output logic [COORD_W-1:0] oBall_y,
    output logic [1:0]         oState,
    output logic               oBounce,
    output logic               oMiss
);

    ball_state_e r_state;
    ball_state_e w_state_next;
    logic [3:0]  r_crash;
    logic [3:0]  w_crash_eff;
    logic        w_serve;
    logic        w_step;
    logic        w_load;
    logic        w_x_bounce;
    logic        w_y_bounce;
    logic        w_x_miss;
    logic        w_y_miss;
    logic        w_any_miss;
    logic        r_bounce;
    logic        r_miss;

    // A crash arriving on the moving tick itself must take part in that step.
    assign w_crash_eff = r_crash | iCrash;
    assign w_serve     = (r_state == ST_IDLE) && iServe;
    assign w_step      = (r_state == ST_RUN) && !iPause && iFrame_tick;
    assign w_load      = w_serve || (r_state == ST_MISS);
    assign w_any_miss  = w_x_miss || w_y_miss;

    ball_axis #(
        .COORD_W     (COORD_W),
        .SPEED_W     (SPEED_W),
        .MIN         (X_MIN),
        .MAX         (X_MAX),
        .INIT        (X_INIT),
        .MISS_AT_MAX (0)
    ) u_axis_x (
        .i_clk          (iVGA_CLK),
        .i_rst_n        (iRST_n),
        .i_load         (w_load),
        .i_step         (w_step),
        .i_crash_min    (w_crash_eff[3]),
        .i_crash_max    (w_crash_eff[2]),
        .i_speed        (iSpeed_x),
        .o_pos          (oBall_x),
        .o_bounce       (w_x_bounce),
        .o_hit_max_miss (w_x_miss)
    );

    ball_axis #(
        .COORD_W     (COORD_W),
        .SPEED_W     (SPEED_W),
        .MIN         (Y_MIN),
        .MAX         (Y_MAX),
        .INIT        (Y_INIT),
        .MISS_AT_MAX (MISS_ON_BOTTOM)
    ) u_axis_y (
        .i_clk          (iVGA_CLK),
        .i_rst_n        (iRST_n),
        .i_load         (w_load),
        .i_step         (w_step),
        .i_crash_min    (w_crash_eff[1]),
        .i_crash_max    (w_crash_eff[0]),
        .i_speed        (iSpeed_y),
        .o_pos          (oBall_y),
        .o_bounce       (w_y_bounce),
        .o_hit_max_miss (w_y_miss)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (iServe) w_state_next = ST_RUN;
            ST_RUN: begin
                if (iPause)                      w_state_next = ST_PAUSED;
                else if (w_step && w_any_miss)   w_state_next = ST_MISS;
            end
            ST_PAUSED: if (!iPause) w_state_next = ST_RUN;
            ST_MISS:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state  <= ST_IDLE;
            r_crash  <= '0;
            r_bounce <= 1'b0;
            r_miss   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_bounce <= w_step && (w_x_bounce || w_y_bounce);
            r_miss   <= w_step && w_any_miss;
            if (w_load || w_step) r_crash <= '0;
            else                  r_crash <= w_crash_eff;
        end
    end

    assign oState  = r_state;
    assign oBounce = r_bounce;
    assign oMiss   = r_miss;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed scoreboard bench for ball_motion_ctrl with a behavioural reference model.
module tb_ball_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       serve = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] crash = 4'b0;
    logic [2:0] sx = 3'd0;
    logic [2:0] sy = 3'd0;
    logic [9:0] bx;
    logic [9:0] by;
    logic [1:0] st;
    logic       bnc;
    logic       mis;
    logic [23:0] obs;

    int checks = 0;
    int failures = 0;

    string       q_tag[$];
    logic [23:0] q_exp[$];

    int m_x, m_y, m_st, m_xd, m_yd, m_b, m_m;
    logic [3:0] m_cr;

    always #5 clk = ~clk;

    assign obs = {bx, by, st, bnc, mis};

    ball_motion_ctrl dut (
        .iVGA_CLK    (clk),
        .iRST_n      (rst_n),
        .iFrame_tick (tick),
        .iServe      (serve),
        .iPause      (pause),
        .iCrash      (crash),
        .iSpeed_x    (sx),
        .iSpeed_y    (sy),
        .oBall_x     (bx),
        .oBall_y     (by),
        .oState      (st),
        .oBounce     (bnc),
        .oMiss       (mis)
    );

    task automatic check(input string tag, input logic [23:0] o, input logic [23:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed={x=%0d y=%0d st=%0d b=%0b m=%0b} expected={x=%0d y=%0d st=%0d b=%0b m=%0b}",
                   tag, o[23:14], o[13:4], o[3:2], o[1], o[0], e[23:14], e[13:4], e[3:2], e[1], e[0]);
        end
    endtask

    function automatic logic [23:0] pack(input int x, input int y, input int s, input int b, input int m);
        return {10'(x), 10'(y), 2'(s), 1'(b), 1'(m)};
    endfunction

    task automatic m_reset();
        m_x = 320; m_y = 240; m_st = 0; m_xd = 0; m_yd = 0; m_b = 0; m_m = 0; m_cr = 4'b0;
    endtask

    // Direction 0 = toward the low bound (left/up), 1 = toward the high bound.
    task automatic axis_model(input int p, input int d, input int cmin, input int cmax, input int spd,
                              input int lo, input int hi, input int miss,
                              output int np, output int nd, output int hit);
        int n;
        nd = d;
        if (cmin != 0 && cmax == 0 && d == 0) nd = 1;
        else if (cmax != 0 && cmin == 0 && d == 1) nd = 0;
        n = (nd == 1) ? p + spd : p - spd;
        hit = 0;
        if (n < lo) begin
            np = lo; nd = 1;
        end else if (n > hi) begin
            np = hi; hit = miss;
            if (miss == 0) nd = 0;
        end else begin
            np = n;
        end
    endtask

    task automatic model_cycle(input logic t, input logic s, input logic p, input logic [3:0] c,
                               input int vx, input int vy);
        int nx, ny, ndx, ndy, hx, hy;
        logic [3:0] eff;
        eff = m_cr | c;
        m_b = 0; m_m = 0;
        case (m_st)
            0: begin
                if (s) begin m_st = 1; m_xd = 0; m_yd = 0; m_cr = 4'b0; end
                else m_cr = eff;
            end
            1: begin
                if (p) begin
                    m_st = 2; m_cr = eff;
                end else if (t) begin
                    axis_model(m_x, m_xd, int'(eff[3]), int'(eff[2]), vx, 0, 632, 0, nx, ndx, hx);
                    axis_model(m_y, m_yd, int'(eff[1]), int'(eff[0]), vy, 0, 472, 1, ny, ndy, hy);
                    m_b = ((ndx != m_xd) || (ndy != m_yd)) ? 1 : 0;
                    m_m = hy;
                    if (hy != 0) m_st = 3;
                    m_x = nx; m_y = ny; m_xd = ndx; m_yd = ndy; m_cr = 4'b0;
                end else begin
                    m_cr = eff;
                end
            end
            2: begin
                m_cr = eff;
                if (!p) m_st = 1;
            end
            default: begin
                m_st = 0; m_x = 320; m_y = 240; m_xd = 0; m_yd = 0; m_cr = 4'b0;
            end
        endcase
    endtask

    task automatic cyc(input string tag, input logic t, input logic s, input logic p,
                       input logic [3:0] c, input logic [2:0] vx, input logic [2:0] vy);
        @(negedge clk);
        tick = t; serve = s; pause = p; crash = c; sx = vx; sy = vy;
        model_cycle(t, s, p, c, int'(vx), int'(vy));
        q_tag.push_back(tag);
        q_exp.push_back(pack(m_x, m_y, m_st, m_b, m_m));
        @(posedge clk);
        #1;
        check(q_tag.pop_front(), obs, q_exp.pop_front());
    endtask

    initial begin
        m_reset();
        #12;
        check("reset_values", obs, pack(320, 240, 0, 0, 0));
        @(negedge clk) rst_n = 1'b1;

        cyc("idle_pause_ignored", 1'b0, 1'b0, 1'b1, 4'b0000, 3'd0, 3'd0);
        cyc("serve", 1'b0, 1'b1, 1'b0, 4'b0000, 3'd2, 3'd2);
        cyc("first_tick", 1'b1, 1'b0, 1'b0, 4'b0000, 3'd2, 3'd2);
        check("first_tick_pos", obs, pack(318, 238, 1, 0, 0));

        for (int i = 0; i < 5; i++)
            cyc("paused_tick", 1'b1, 1'b0, 1'b1, (i == 2) ? 4'b1000 : 4'b0000, 3'd2, 3'd2);
        check("pause_frozen", obs, pack(318, 238, 2, 0, 0));
        cyc("unpause", 1'b0, 1'b0, 1'b0, 4'b0000, 3'd2, 3'd2);
        cyc("resume_tick", 1'b1, 1'b0, 1'b0, 4'b0000, 3'd2, 3'd2);
        check("paused_crash_applied", obs, pack(320, 236, 1, 1, 0));

        for (int i = 0; i < 44; i++)
            cyc("run_right", 1'b1, 1'b0, 1'b0, 4'b0000, 3'd7, 3'd0);
        cyc("to_631", 1'b1, 1'b0, 1'b0, 4'b0000, 3'd3, 3'd0);
        check("at_631", obs, pack(631, 236, 1, 0, 0));
        cyc("right_wall", 1'b1, 1'b0, 1'b0, 4'b0000, 3'd3, 3'd0);
        check("right_wall_clamp", obs, pack(632, 236, 1, 1, 0));
        cyc("bounce_one_cycle", 1'b0, 1'b0, 1'b0, 4'b0000, 3'd3, 3'd0);
        check("bounce_cleared", obs, pack(632, 236, 1, 0, 0));

        for (int i = 0; i < 76; i++)
            cyc("run_left", 1'b1, 1'b0, 1'b0, 4'b0000, 3'd7, 3'd0);
        check("at_100", obs, pack(100, 236, 1, 0, 0));
        cyc("right_crash_latch", 1'b0, 1'b0, 1'b0, 4'b0100, 3'd2, 3'd0);
        cyc("right_crash_tick", 1'b1, 1'b0, 1'b0, 4'b0000, 3'd2, 3'd0);
        check("right_crash_no_flip", obs, pack(98, 236, 1, 0, 0));
        cyc("both_crash_tick", 1'b1, 1'b0, 1'b0, 4'b1100, 3'd2, 3'd0);
        check("both_crash_no_flip", obs, pack(96, 236, 1, 0, 0));
        cyc("left_crash_tick", 1'b1, 1'b0, 1'b0, 4'b1000, 3'd2, 3'd0);
        check("left_crash_flip", obs, pack(98, 236, 1, 1, 0));
        cyc("right_crash_flip", 1'b1, 1'b0, 1'b0, 4'b0100, 3'd2, 3'd0);
        check("right_crash_flip_pos", obs, pack(96, 236, 1, 1, 0));

        for (int i = 0; i < 13; i++)
            cyc("run_left2", 1'b1, 1'b0, 1'b0, 4'b0000, 3'd7, 3'd0);
        cyc("left_wall", 1'b1, 1'b0, 1'b0, 4'b0000, 3'd7, 3'd0);
        check("left_wall_underflow", obs, pack(0, 236, 1, 1, 0));
        cyc("zero_speed_up_crash", 1'b1, 1'b0, 1'b0, 4'b0010, 3'd0, 3'd0);
        check("zero_speed_reversal", obs, pack(0, 236, 1, 1, 0));

        cyc("y_to_238", 1'b1, 1'b0, 1'b0, 4'b0000, 3'd0, 3'd2);
        for (int i = 0; i < 58; i++)
            cyc("run_down", 1'b1, 1'b0, 1'b0, 4'b0000, 3'd0, 3'd4);
        check("at_470", obs, pack(0, 470, 1, 0, 0));
        cyc("miss_tick", 1'b1, 1'b1, 1'b0, 4'b0000, 3'd0, 3'd4);
        check("miss_state", obs, pack(0, 472, 3, 0, 1));
        cyc("miss_to_idle", 1'b0, 1'b0, 1'b1, 4'b0000, 3'd0, 3'd0);
        check("idle_after_miss", obs, pack(320, 240, 0, 0, 0));
        cyc("idle_tick_ignored", 1'b1, 1'b0, 1'b0, 4'b0000, 3'd2, 3'd2);
        cyc("serve2", 1'b0, 1'b1, 1'b0, 4'b0000, 3'd2, 3'd2);
        cyc("serve2_crash_tick", 1'b1, 1'b0, 1'b0, 4'b1000, 3'd2, 3'd2);
        check("serve2_bounce", obs, pack(322, 238, 1, 1, 0));

        // Asynchronous reset in the middle of a tick cycle while a bounce pulse is high.
        tick = 1'b1;
        #2 rst_n = 1'b0;
        #1 check("async_reset_immediate", obs, pack(320, 240, 0, 0, 0));
        @(posedge clk);
        #1 check("async_reset_held", obs, pack(320, 240, 0, 0, 0));
        m_reset();
        @(negedge clk);
        tick = 1'b0;
        rst_n = 1'b1;
        cyc("post_reset_serve", 1'b0, 1'b1, 1'b0, 4'b0000, 3'd2, 3'd2);
        cyc("post_reset_tick", 1'b1, 1'b0, 1'b0, 4'b0000, 3'd2, 3'd2);
        check("post_reset_pos", obs, pack(318, 238, 1, 0, 0));

        check("scoreboard_drained", 24'(q_exp.size()), 24'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
